// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bundle between EX-stage control and the
// nibble-serial adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, co, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, co, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 4-bit carry-select slice is
// reused for WIDTH/4 cycles, with the carry held in a register between nibbles.
module nsa_csel4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;
    logic [2:0] hi;

    // Low pair ripples from ci; high pair is precomputed for both carries.
    assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, ci};
    assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign hi1 = hi0 + 3'd1;
    assign hi  = lo[2] ? hi1 : hi0;
    assign sum = {hi[1:0], lo[1:0]};
    assign co  = hi[2];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 carry_q;
    logic [NIB-1:0][3:0]  a_q;
    logic [NIB-1:0][3:0]  b_q;
    logic [NIB-1:0][3:0]  sum_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 co_q;
    logic                 ovf_q;

    logic [3:0]           nib_sum;
    logic                 nib_co;
    logic                 accept;
    logic                 last_nib;

    assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last_nib = (idx_q == IDX_W'(NIB - 1));

    nsa_csel4 u_slice (
        .a   (a_q[idx_q]),
        .b   (b_q[idx_q]),
        .ci  (carry_q),
        .sum (nib_sum),
        .co  (nib_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        // Subtraction is a + ~b + 1: invert B here, seed the carry with sub.
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        co_q    <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= nib_sum;
                    carry_q      <= nib_co;
                    idx_q        <= idx_q + 1'b1;
                    if (last_nib) begin
                        co_q    <= nib_co;
                        ovf_q   <= (a_q[NIB-1][3] == b_q[NIB-1][3]) &&
                                   (nib_sum[3] != a_q[NIB-1][3]);
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: stimulus queues expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_nibble_serial_adder;
    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
        int               acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic finish_sim();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        exp_t e;
        logic [WIDTH:0] r;
        r = {1'b0, x} + {1'b0, (s ? ~y : y)} + {{WIDTH{1'b0}}, s};
        e.sum = r[WIDTH-1:0];
        e.co  = r[WIDTH];
        if (s) e.ovf = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        else   e.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        e.acc = 0;
        return e;
    endfunction

    // Caller must be at a negedge with busy low, so the next edge accepts.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                         input logic [WIDTH-1:0] es, input logic eco, input logic eovf);
        exp_t e;
        bus.a     = x;
        bus.b     = y;
        bus.sub   = s;
        bus.start = 1'b1;
        e.sum = es;
        e.co  = eco;
        e.ovf = eovf;
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (bus.done) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL done_timeout: got no done within 40 cycles expected done");
        finish_sim();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_excl", {63'b0, bus.busy & bus.done}, 64'd0);
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
                end else begin
                    mon_e = q.pop_front();
                    check("sum", {32'b0, bus.sum}, {32'b0, mon_e.sum});
                    check("co", {63'b0, bus.co}, {63'b0, mon_e.co});
                    check("ovf", {63'b0, bus.ovf}, {63'b0, mon_e.ovf});
                    check("latency", 64'(cyc), 64'(mon_e.acc + NIB));
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             s;
        int               gap;

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        check("rst_sum", {32'b0, bus.sum}, 64'd0);
        check("rst_co", {63'b0, bus.co}, 64'd0);
        check("rst_ovf", {63'b0, bus.ovf}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        wait_done();
        @(negedge clk);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        wait_done();
        issue(32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0);
        check("b2b_busy", {63'b0, bus.busy}, 64'd1);
        check("b2b_done_pulse", {63'b0, bus.done}, 64'd0);
        wait_done();
        @(negedge clk);

        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        wait_done();
        @(negedge clk);

        // start held high through RUN while operands churn
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h0FED_CBA8;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        e.sum = 32'h2222_2220;
        e.co  = 1'b0;
        e.ovf = 1'b0;
        e.acc = cyc + 1;
        q.push_back(e);
        for (int i = 0; i < 40 && !bus.done; i++) begin
            @(negedge clk);
            if (!bus.done) begin
                bus.a   = $urandom;
                bus.b   = $urandom;
                bus.sub = 1'($urandom_range(0, 1));
            end
        end
        bus.start = 1'b0;
        check("held_start_done_seen", {63'b0, bus.done}, 64'd1);
        @(negedge clk);
        check("held_start_no_reaccept", {63'b0, bus.busy}, 64'd0);

        // asynchronous reset in the third RUN cycle
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, bus.busy}, 64'd0);
        check("abort_done", {63'b0, bus.done}, 64'd0);
        check("abort_sum", {32'b0, bus.sum}, 64'd0);
        check("abort_co", {63'b0, bus.co}, 64'd0);
        check("abort_ovf", {63'b0, bus.ovf}, 64'd0);
        void'(q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_stays_idle", {63'b0, bus.busy}, 64'd0);
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            x = $urandom;
            y = $urandom;
            s = 1'($urandom_range(0, 1));
            e = model(x, y, s);
            issue(x, y, s, e.sum, e.co, e.ovf);
            wait_done();
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        finish_sim();
    end
endmodule
